// File: rtl/mac_acc_mp_if.sv
// Handshake/bus bundle for mac_acc_mp: input beat stream and psum output.
// The producer and consumer side use the master modport; the MAC uses slave.
interface mac_acc_mp_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 24,
    parameter int CNT_BW  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic        [BW-1:0]     a;
    logic signed [BW-1:0]     b;
    logic                     act_mode;
    logic        [CNT_BW-1:0] acc_len;
    logic                     out_valid;
    logic                     out_ready;
    logic        [PSUM_BW-1:0] out;
    logic                     busy;

    modport master (
        output in_valid, a, b, act_mode, acc_len, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, act_mode, acc_len, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/mac_acc_mp.sv
// mac_acc_mp: pipelined multi-precision MAC accumulator for the PE array.
// Mode 0 accumulates one full-width lane; mode 1 accumulates two independent
// half-width lanes packed as {lane1, lane0}. Two stages: product register,
// then accumulate. Define MAC_SAT_EN for saturating adds instead of wrap.
module mac_acc_mp #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 24,
    parameter int CNT_BW  = 8
) (
    input logic          clk,
    input logic          reset_n,
    mac_acc_mp_if.slave  bus
);
    localparam int LW     = PSUM_BW / 2;
    localparam int HB     = BW / 2;
    localparam int FPW    = 2 * BW + 1;
    localparam int LPW    = HB + BW + 1;
    // vld_pipe[0]: product register holds a beat; vld_pipe[1]: beat folded on last edge
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_t;

    state_t               state;
    logic                 in_ready_r, out_valid_r, busy_r;
    logic [PSUM_BW-1:0]   out_r;
    logic [CNT_BW-1:0]    cnt, grp_len, len_in;
    logic                 grp_mode;
    logic                 accept;
    logic [STAGES:0]      vld_pipe;

    logic signed [FPW-1:0] prod_full, p_full;
    logic signed [LPW-1:0] prod_l0, prod_l1, p_l0, p_l1;
    logic [PSUM_BW-1:0]    acc;

    assign accept  = bus.in_valid && in_ready_r;
    assign len_in  = (bus.acc_len == '0) ? CNT_BW'(1) : bus.acc_len;

    // Unsigned activation gets a zero MSB so the signed multiply treats it as positive
    assign prod_full = $signed({1'b0, bus.a}) * $signed(bus.b);
    assign prod_l0   = $signed({1'b0, bus.a[HB-1:0]}) * $signed(bus.b);
    assign prod_l1   = $signed({1'b0, bus.a[BW-1:HB]}) * $signed(bus.b);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.busy      = busy_r;

`ifdef MAC_SAT_EN
    function automatic logic [PSUM_BW-1:0] add_full(input logic [PSUM_BW-1:0] x, input logic [PSUM_BW-1:0] y);
        logic [PSUM_BW:0] s;
        s = {x[PSUM_BW-1], x} + {y[PSUM_BW-1], y};
        if (s[PSUM_BW] != s[PSUM_BW-1])
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        return s[PSUM_BW-1:0];
    endfunction

    function automatic logic [LW-1:0] add_lane(input logic [LW-1:0] x, input logic [LW-1:0] y);
        logic [LW:0] s;
        s = {x[LW-1], x} + {y[LW-1], y};
        if (s[LW] != s[LW-1])
            return s[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
        return s[LW-1:0];
    endfunction
`else
    function automatic logic [PSUM_BW-1:0] add_full(input logic [PSUM_BW-1:0] x, input logic [PSUM_BW-1:0] y);
        return x + y;
    endfunction

    function automatic logic [LW-1:0] add_lane(input logic [LW-1:0] x, input logic [LW-1:0] y);
        return x + y;
    endfunction
`endif

    // Group control: latch mode/length on the first beat, count beats, drain, hold psum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_r       <= '0;
            cnt         <= '0;
            grp_len     <= '0;
            grp_mode    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    grp_mode <= bus.act_mode;
                    grp_len  <= len_in;
                    cnt      <= CNT_BW'(1);
                    busy_r   <= 1'b1;
                    if (len_in == CNT_BW'(1)) begin
                        state      <= FLUSH;
                        in_ready_r <= 1'b0;
                    end else begin
                        state <= ACC;
                    end
                end
                ACC: if (accept) begin
                    cnt <= cnt + CNT_BW'(1);
                    if (cnt + CNT_BW'(1) == grp_len) begin
                        state      <= FLUSH;
                        in_ready_r <= 1'b0;
                    end
                end
                // Last beat was folded on the previous edge and nothing is behind it
                FLUSH: if (!vld_pipe[0] && vld_pipe[1]) begin
                    state       <= HOLD;
                    out_valid_r <= 1'b1;
                    out_r       <= acc;
                end
                HOLD: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: stage 1 captures lane products, stage 2 folds them into the accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            p_full   <= '0;
            p_l0     <= '0;
            p_l1     <= '0;
            acc      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (accept) begin
                p_full <= prod_full;
                p_l0   <= prod_l0;
                p_l1   <= prod_l1;
            end
            // A group's first beat only arrives once the pipeline has drained
            if (accept && state == IDLE)
                acc <= '0;
            else if (vld_pipe[0]) begin
                if (grp_mode)
                    acc <= {add_lane(acc[PSUM_BW-1:LW], LW'(p_l1)),
                            add_lane(acc[LW-1:0],       LW'(p_l0))};
                else
                    acc <= add_full(acc, PSUM_BW'(p_full));
            end
        end
    end
endmodule

// File: tb/tb_mac_acc_mp.sv
// Self-checking bench for mac_acc_mp: directed cases plus random groups
// compared against an arithmetic reference of the accumulate rules.
module tb_mac_acc_mp;
    localparam int BW  = 4;
    localparam int PB  = 24;
    localparam int CB  = 8;
    localparam int PB2 = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mac_acc_mp_if #(.BW(BW), .PSUM_BW(PB),  .CNT_BW(CB)) bus1 ();
    mac_acc_mp_if #(.BW(BW), .PSUM_BW(PB2), .CNT_BW(CB)) bus2 ();

    mac_acc_mp #(.BW(BW), .PSUM_BW(PB),  .CNT_BW(CB)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    mac_acc_mp #(.BW(BW), .PSUM_BW(PB2), .CNT_BW(CB)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int ga[$];
    int gb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic longint fold(input longint acc, input longint p, input int w);
        longint half, s;
        half = longint'(1) << (w - 1);
        s = acc + p;
`ifdef MAC_SAT_EN
        if (s > half - 1) s = half - 1;
        if (s < -half)    s = -half;
`else
        s = s & (2 * half - 1);
        if (s >= half) s = s - 2 * half;
`endif
        return s;
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: sum a*b over the beats in ga/gb, per lane in mode 1
    function automatic logic [63:0] model(input int mode, input int n, input int w);
        longint s = 0, l0 = 0, l1 = 0;
        int lw = w / 2;
        int hd = 1 << (BW / 2);
        for (int i = 0; i < n; i++) begin
            if (mode == 0)
                s = fold(s, longint'(ga[i]) * gb[i], w);
            else begin
                l0 = fold(l0, longint'(ga[i] % hd) * gb[i], lw);
                l1 = fold(l1, longint'(ga[i] / hd) * gb[i], lw);
            end
        end
        if (mode == 0) return 64'(s) & msk(w);
        return ((64'(l1) & msk(lw)) << lw) | (64'(l0) & msk(lw));
    endfunction

    // Present one beat and wait for the edge that accepts it
    task automatic send(input int a, input int b, input int mode, input int len);
        int n = 0;
        bus1.in_valid = 1'b1;
        bus1.a        = BW'(a);
        bus1.b        = BW'(b);
        bus1.act_mode = mode[0];
        bus1.acc_len  = CB'(len);
        while (bus1.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo("accept");
        @(posedge clk);
        @(negedge clk);
        last_acc = cyc;
    endtask

    // Wait for psum, check latency/value, optionally stall, then consume it
    task automatic collect(input string tag, input logic [63:0] exp, input int stall);
        int n = 0;
        while (bus1.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo({tag, "_valid"});
        chk({tag, "_lat"}, 64'(cyc - last_acc), 64'd2);
        chk({tag, "_out"}, 64'(bus1.out), exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_out"}, 64'(bus1.out), exp);
            chk({tag, "_stall_vld"}, 64'(bus1.out_valid), 64'd1);
        end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk({tag, "_done_vld"}, 64'(bus1.out_valid), 64'd0);
        chk({tag, "_done_rdy"}, 64'(bus1.in_ready), 64'd1);
    endtask

    // Drive the beats queued in ga/gb as one group; optional gaps and mid-group noise
    task automatic run_group(input string tag, input int mode, input int len,
                             input bit gaps, input bit toggle, input int stall);
        int n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            if (toggle && i > 0) send(ga[i], gb[i], 1 - mode, 1);
            else                 send(ga[i], gb[i], mode, len);
            if (gaps && i < n - 1 && $urandom_range(0, 1) == 1) begin
                bus1.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus1.in_valid = 1'b0;
        collect(tag, model(mode, n, PB), stall);
    endtask

    task automatic fill(input int a, input int b, input int n);
        ga.delete();
        gb.delete();
        for (int i = 0; i < n; i++) begin
            ga.push_back(a);
            gb.push_back(b);
        end
    endtask

    initial begin
        int n;
        logic [63:0] e6;
        reset_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.act_mode = 1'b0;
        bus1.acc_len = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.act_mode = 1'b0;
        bus2.acc_len = '0; bus2.out_ready = 1'b0;
        #1;
        chk("rst_out", 64'(bus1.out), 64'd0);
        chk("rst_vld", 64'(bus1.out_valid), 64'd0);
        chk("rst_busy", 64'(bus1.busy), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 64'(bus1.in_ready), 64'd1);

        // 1: mode 0, three beats 15 * -8
        fill(15, -8, 3);
        run_group("t1", 0, 3, 1'b0, 1'b0, 0);
        chk("t1_const", 64'(bus1.out), 64'hFFFE98);

        // 2: mode 1, two beats 0xB * 7
        fill(11, 7, 2);
        run_group("t2", 1, 2, 1'b0, 1'b0, 0);
        chk("t2_const", 64'(bus1.out), 64'h01C02A);

        // 3: lane isolation, negative lanes
        fill(15, -8, 1);
        run_group("t3", 1, 1, 1'b0, 1'b0, 0);
        chk("t3_const", 64'(bus1.out), 64'hFE8FE8);

        // 4: backpressure with a pending beat held on the input
        ga.delete(); gb.delete();
        ga.push_back(2); gb.push_back(-3);
        ga.push_back(1); gb.push_back(1);
        send(2, -3, 0, 2);
        send(1, 1, 0, 2);
        bus1.in_valid = 1'b1; bus1.a = 4'd5; bus1.b = 4'sd3; bus1.act_mode = 1'b0; bus1.acc_len = 8'd1;
        n = 0;
        while (bus1.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo("t4_valid");
        chk("t4_lat", 64'(cyc - last_acc), 64'd2);
        chk("t4_out", 64'(bus1.out), model(0, 2, PB));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_out", 64'(bus1.out), 64'hFFFFFB);
            chk("t4_stall_rdy", 64'(bus1.in_ready), 64'd0);
            chk("t4_stall_vld", 64'(bus1.out_valid), 64'd1);
        end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk("t4_rel_vld", 64'(bus1.out_valid), 64'd0);
        chk("t4_rel_rdy", 64'(bus1.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        last_acc = cyc;
        bus1.in_valid = 1'b0;
        collect("t4_next", 64'd15, 0);

        // 5: reset mid-group discards in-flight data
        send(3, 5, 0, 4);
        send(3, 5, 0, 4);
        bus1.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t5_out", 64'(bus1.out), 64'd0);
        chk("t5_vld", 64'(bus1.out_valid), 64'd0);
        chk("t5_busy", 64'(bus1.busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_rdy", 64'(bus1.in_ready), 64'd1);
        fill(1, 1, 1);
        run_group("t5_after", 0, 1, 1'b0, 1'b0, 0);
        chk("t5_const", 64'(bus1.out), 64'd1);

        // 5b: act_mode/acc_len changes after the first beat are ignored
        ga.delete(); gb.delete();
        ga.push_back(11); gb.push_back(-5);
        ga.push_back(6);  gb.push_back(7);
        ga.push_back(9);  gb.push_back(-8);
        run_group("t5_toggle", 1, 3, 1'b0, 1'b1, 0);

        // Random groups with gaps and output stalls
        for (int g = 0; g < 12; g++) begin
            int mode, len, nb;
            mode = int'($urandom_range(0, 1));
            len  = int'($urandom_range(0, 7));
            nb   = (len == 0) ? 1 : len;
            ga.delete(); gb.delete();
            for (int i = 0; i < nb; i++) begin
                ga.push_back(int'($urandom_range(0, 15)));
                gb.push_back(int'($urandom_range(0, 15)) - 8);
            end
            run_group($sformatf("rnd%0d", g), mode, len, 1'b1, 1'b0, int'($urandom_range(0, 3)));
        end

        // 6: narrow psum, 20 beats of 15 * 7 in mode 0
        fill(15, 7, 20);
        bus2.in_valid = 1'b1; bus2.a = 4'd15; bus2.b = 4'sd7; bus2.act_mode = 1'b0; bus2.acc_len = 8'd20;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (bus2.in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) tmo("t6_accept");
            @(posedge clk);
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        n = 0;
        while (bus2.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo("t6_valid");
`ifdef MAC_SAT_EN
        e6 = 64'h7FF;
`else
        e6 = 64'h834;
`endif
        chk("t6_model", 64'(bus2.out), model(0, 20, PB2));
        chk("t6_const", 64'(bus2.out), e6);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        chk("t6_done_rdy", 64'(bus2.in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
